// File: rtl/seq_b_loader.sv
// Sequence-B RAM write front end.
// Turns an ASCII nucleotide stream into sequential 3-bit RAM writes.
module seq_b_loader #(
    parameter int N      = 128,
    parameter int Bit    = $clog2(N),
    parameter int LenBit = $clog2(N + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              en_din,
    output logic              we,
    output logic [Bit-1:0]    addr_din,
    output logic [2:0]        din,
    output logic [LenBit-1:0] len_b,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE,
        ERR
    } state_t;

    localparam logic [1:0] EC_NONE  = 2'b00;
    localparam logic [1:0] EC_BAD   = 2'b01;
    localparam logic [1:0] EC_EMPTY = 2'b10;

    localparam logic [LenBit-1:0] LAST_IDX = LenBit'(N - 1);

    state_t            state_q;
    state_t            state_d;
    logic [LenBit-1:0] cnt_q;
    logic [LenBit-1:0] cnt_d;
    logic              wr_q;
    logic              wr_d;
    logic [Bit-1:0]    addr_q;
    logic [2:0]        din_q;
    logic [1:0]        ec_q;
    logic [1:0]        ec_d;

    logic [2:0]        code;
    logic              is_nuc;
    logic              is_term;
    logic              accept;
    logic              last;

    // Character classification and nucleotide code lookup.
    always_comb begin
        code    = 3'b000;
        is_nuc  = 1'b0;
        is_term = 1'b0;
        unique case (in_data)
            8'h47, 8'h67: begin
                code   = 3'b001;
                is_nuc = 1'b1;
            end
            8'h43, 8'h63: begin
                code   = 3'b110;
                is_nuc = 1'b1;
            end
            8'h41, 8'h61: begin
                code   = 3'b100;
                is_nuc = 1'b1;
            end
            8'h54, 8'h74: begin
                code   = 3'b011;
                is_nuc = 1'b1;
            end
            8'h0A, 8'h0D, 8'h00: begin
                is_term = 1'b1;
            end
            default: begin
                is_term = 1'b0;
            end
        endcase
    end

    // Ready comes only from the registered state.
    assign in_ready = (state_q == LOAD);
    assign accept   = in_valid & in_ready;
    assign last     = (cnt_q == LAST_IDX);

    // Next state, write request, index and error code.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = 1'b0;
        ec_d    = ec_q;
        if (start) begin
            state_d = LOAD;
            cnt_d   = '0;
            ec_d    = EC_NONE;
        end else if (accept) begin
            unique case (1'b1)
                is_nuc: begin
                    wr_d  = 1'b1;
                    cnt_d = cnt_q + LenBit'(1);
                    if (last) begin
                        state_d = DONE;
                    end
                end
                is_term: begin
                    if (cnt_q != '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = ERR;
                        ec_d    = EC_EMPTY;
                    end
                end
                default: begin
                    state_d = ERR;
                    ec_d    = EC_BAD;
                end
            endcase
        end
    end

    // State, counters and the registered RAM write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            ec_q    <= EC_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            ec_q    <= ec_d;
            if (wr_d) begin
                addr_q <= cnt_q[Bit-1:0];
                din_q  <= code;
            end
        end
    end

    assign en_din   = wr_q;
    assign we       = wr_q;
    assign addr_din = addr_q;
    assign din      = din_q;
    assign len_b    = cnt_q;
    assign done     = (state_q == DONE);
    assign err      = (state_q == ERR);
    assign err_code = ec_q;

endmodule

// File: tb/tb_seq_b_loader.sv
// Randomized bench for seq_b_loader.
// Each load's expected writes and status come from a string-level model.
module tb_seq_b_loader;

    localparam int N      = 128;
    localparam int Bit    = $clog2(N);
    localparam int LenBit = $clog2(N + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              en_din;
    logic              we;
    logic [Bit-1:0]    addr_din;
    logic [2:0]        din;
    logic [LenBit-1:0] len_b;
    logic              done;
    logic              err;
    logic [1:0]        err_code;

    int checks = 0;
    int errors = 0;

    byte unsigned str[$];

    seq_b_loader #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .en_din   (en_din),
        .we       (we),
        .addr_din (addr_din),
        .din      (din),
        .len_b    (len_b),
        .done     (done),
        .err      (err),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic int nuc_code(input byte unsigned b);
        case (b)
            "G", "g": return 1;
            "C", "c": return 6;
            "A", "a": return 4;
            "T", "t": return 3;
            default:  return -1;
        endcase
    endfunction

    function automatic bit is_term(input byte unsigned b);
        return (b == 8'h0A) || (b == 8'h0D) || (b == 8'h00);
    endfunction

    function automatic byte unsigned rand_nuc();
        string s;
        s = "GCATgcat";
        return s[$urandom_range(0, 7)];
    endfunction

    task automatic set_str(input string s);
        str.delete();
        for (int i = 0; i < s.len(); i++) begin
            str.push_back(s[i]);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ready"}, in_ready, 0);
        chk({tag, "_en"}, en_din, 0);
        chk({tag, "_we"}, we, 0);
        chk({tag, "_addr"}, addr_din, 0);
        chk({tag, "_din"}, din, 0);
        chk({tag, "_len"}, len_b, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_ec"}, err_code, 0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("st_ready", in_ready, 1);
        chk("st_len", len_b, 0);
        chk("st_done", done, 0);
        chk("st_err", err, 0);
        chk("st_ec", err_code, 0);
    endtask

    // Loads str with random gaps in [mingap,maxgap] and checks every cycle.
    task automatic run_load(input int mingap, input int maxgap);
        int nv;
        int writes;
        int consumed;
        int exp_done;
        int exp_err;
        int exp_ec;
        int gap;
        nv = 0;
        while (nv < str.size() && nuc_code(str[nv]) >= 0) nv++;
        writes   = (nv < N) ? nv : N;
        exp_done = 0;
        exp_err  = 0;
        exp_ec   = 0;
        if (nv >= N) begin
            consumed = N;
            exp_done = 1;
        end else begin
            consumed = nv + 1;
            if (is_term(str[nv]) && nv > 0) begin
                exp_done = 1;
            end else begin
                exp_err = 1;
                exp_ec  = is_term(str[nv]) ? 2 : 1;
            end
        end
        pulse_start();
        for (int i = 0; i < consumed; i++) begin
            gap = $urandom_range(mingap, maxgap);
            repeat (gap) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(negedge clk);
                chk("gap_we", we, 0);
                chk("gap_en", en_din, 0);
            end
            in_valid = 1'b1;
            in_data  = str[i];
            chk("ready", in_ready, 1);
            @(negedge clk);
            in_valid = 1'b0;
            if (i < writes) begin
                chk("wr_we", we, 1);
                chk("wr_en", en_din, 1);
                chk("wr_addr", addr_din, i);
                chk("wr_din", din, nuc_code(str[i]));
                chk("wr_len", len_b, i + 1);
            end else begin
                chk("nowr_we", we, 0);
                chk("nowr_en", en_din, 0);
            end
            if (i == consumed - 1) begin
                chk("end_done", done, exp_done);
                chk("end_err", err, exp_err);
                chk("end_ec", err_code, exp_ec);
                chk("end_len", len_b, writes);
            end else begin
                chk("mid_done", done, 0);
                chk("mid_err", err, 0);
            end
        end
        repeat (2) begin
            in_valid = 1'b1;
            in_data  = rand_nuc();
            @(negedge clk);
            chk("hold_ready", in_ready, 0);
            chk("hold_we", we, 0);
            chk("hold_done", done, exp_done);
            chk("hold_err", err, exp_err);
            chk("hold_ec", err_code, exp_ec);
            chk("hold_len", len_b, writes);
        end
        in_valid = 1'b0;
    endtask

    task automatic gen_random();
        int kind;
        int nv;
        byte unsigned b;
        str.delete();
        kind = $urandom_range(0, 9);
        if (kind == 0) begin
            nv = N + $urandom_range(0, 3);
        end else begin
            nv = $urandom_range(0, 12);
        end
        for (int i = 0; i < nv; i++) str.push_back(rand_nuc());
        if (kind < 6) begin
            case ($urandom_range(0, 2))
                0:       str.push_back(8'h0A);
                1:       str.push_back(8'h0D);
                default: str.push_back(8'h00);
            endcase
        end else begin
            b = 8'($urandom);
            while (nuc_code(b) >= 0 || is_term(b)) b = 8'($urandom);
            str.push_back(b);
        end
        str.push_back(rand_nuc());
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_zero("rst");
        rst = 1'b0;
        @(negedge clk);
        check_zero("idle");

        set_str("GATGC\n");
        run_load(0, 0);

        set_str("gAtC");
        str.push_back(8'h0D);
        run_load(3, 3);

        set_str("GAX");
        run_load(0, 0);
        set_str("T\n");
        run_load(0, 0);

        set_str("\n");
        run_load(0, 1);

        str.delete();
        for (int i = 0; i < N; i++) str.push_back(rand_nuc());
        str.push_back("A");
        run_load(0, 0);

        for (int k = 0; k < 30; k++) begin
            gen_random();
            run_load(0, $urandom_range(0, 2));
        end

        pulse_start();
        in_valid = 1'b1;
        in_data  = "G";
        @(negedge clk);
        in_data = "A";
        @(negedge clk);
        chk("pre_rst_we", we, 1);
        chk("pre_rst_len", len_b, 2);
        in_data = "T";
        rst     = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("midrst");
        @(negedge clk);
        chk("idle_ready", in_ready, 0);
        chk("idle_we", we, 0);
        in_valid = 1'b0;
        start    = 1'b1;
        rst      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        check_zero("strst");
        @(negedge clk);
        chk("strst_ready2", in_ready, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_b_loader.md
Name: seq_b_loader

Overview:
- Write-side front end for the sequence-B RAM.
- Accepts an ASCII nucleotide stream over a valid/ready handshake and converts each character to the 3-bit nucleotide code.
- Drives the RAM write port (en_din/we/addr_din/din) sequentially from address 0, counts the sequence length and reports done or error.
- Sits between the host/UART byte source and the sequence-B RAM, ahead of the NW matrix-fill controller, which consumes len_b.

Parameters:
N, 128, RAM depth and maximum sequence length.
Bit, $clog2(N), RAM address width.
LenBit, $clog2(N+1), width of the length count (0..N inclusive).

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins a new load from any state
in_data  input  8  ASCII character
in_valid  input  1  in_data valid
in_ready  output  1  loader can accept a character
en_din  output  1  RAM write-port enable
we  output  1  RAM write strobe
addr_din  output  Bit  RAM write address
din  output  3  nucleotide code to write
len_b  output  LenBit  number of nucleotides written
done  output  1  load complete, len_b valid (level)
err  output  1  load aborted (level)
err_code  output  2  01 invalid character, 10 empty sequence, 00 none

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; all outputs 0, including in_ready, en_din, we, addr_din, din, len_b, done, err and err_code. Reset overrides start. Reset mid-load abandons the load; RAM contents beyond this point are undefined.
- Code map:
  - G/g -> 001
  - C/c -> 110
  - A/a -> 100
  - T/t -> 011
- Terminators: 0x0A, 0x0D, 0x00. Any other byte is invalid.
- States: IDLE, LOAD, DONE, ERR.
- in_ready = 1 only in LOAD, decoded from the registered state with no combinational path from in_valid.
- Accept = in_valid && in_ready. in_data is ignored when there is no accept.
- start in any state (including LOAD, DONE, ERR): next state LOAD; clear internal index, len_b, done, err and err_code. Any write pending in the same cycle still completes.
- LOAD, accept of a valid nucleotide at edge k:
  - At cycle k+1: en_din=1, we=1, addr_din=index, din=code, each for exactly one cycle.
  - index increments; len_b = index+1 from cycle k+1.
  - If this was the N-th nucleotide (index==N-1): state DONE at k+1, so done=1 together with the final write.
- LOAD, accept of a terminator:
  - If len_b>0: state DONE at k+1, done=1, no write.
  - If len_b==0: state ERR, err=1, err_code=10.
- LOAD, accept of an invalid byte: state ERR at k+1, err=1, err_code=01, no write. len_b keeps the count written so far.
- DONE/ERR: in_ready=0; done/err hold until start or rst. done and err are never both 1.
- Gaps in in_valid stall the load with no timeout. en_din/we stay 0 when there is no accept.
- Throughput: one character per cycle while in_valid is held.
- en_din and we are always identical, and both are registered outputs.

Test Plan:
- start, then "GATGC\n" back-to-back (N=128) -> writes addr 0..4 with din 001,100,011,001,110 on consecutive cycles, each one cycle after its accept; done=1 the cycle after '\n'; len_b=5; err=0.
- start, "gAtC\r" with in_valid deasserted 3 cycles between characters -> 4 writes with codes 001,100,011,110 and no spurious we during gaps; len_b=4; done=1.
- N=5 build, start, "GATGCA" with no terminator -> 5 writes; done=1 in the same cycle as the write to addr 4 (din=110); in_ready=0 afterwards; the 'A' is never accepted.
- start, "GAX" -> writes addr 0,1 only; err=1, err_code=01, len_b=2, done=0. A second start followed by "T\n" -> err clears; write addr0=011; len_b=1; done=1.
- start, "\n" -> err=1, err_code=10, len_b=0, no write.
- start, "GA", rst=1 for one cycle while in_valid is high -> next cycle all outputs 0, state IDLE, in_ready=0. start together with rst -> stays IDLE.
